// File: rtl/rle_symbol_packer.sv
// Serialises one 8-lane run-length row into JPEG AC symbols: (run,value), ZRL or EOB.
// It emits one symbol per handshake and holds off upstream until the row has drained.
module rle_symbol_packer #(
   parameter int COEF_W = 8,
   parameter int RUN_W  = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  row_valid,
   output logic                  row_ready,
   input  logic [8*COEF_W-1:0]   row_coef,
   input  logic [7:0]            row_en,
   input  logic [8*RUN_W-1:0]    row_run,
   input  logic                  row_last,
   output logic                  sym_valid,
   input  logic                  sym_ready,
   output logic [1:0]            sym_type,
   output logic [3:0]            sym_run,
   output logic [COEF_W-1:0]     sym_val,
   output logic                  sym_last
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EMIT = 2'd1;
   localparam logic [1:0] S_EOB  = 2'd2;

   localparam int ZW = RUN_W - 4;

   logic [1:0]                  state;
   logic                        init_q;
   logic [7:0]                  mask_q;
   logic                        last_q;
   logic [ZW-1:0]               zrl_q;
   logic [7:0][COEF_W-1:0]      coef_q;
   logic [7:0][RUN_W-1:0]       run_q;

   // Internal index 0 is lane1, which arrives in the input MSBs
   logic [7:0]                  in_en;
   logic [7:0][COEF_W-1:0]      in_coef;
   logic [7:0][RUN_W-1:0]       in_run;
   logic [2:0]                  in_first;
   logic [2:0]                  cur;
   logic [2:0]                  nxt;
   logic [7:0]                  rest;
   logic                        accept;
   logic                        is_zrl;

   always_comb begin
      in_en    = '0;
      in_coef  = '0;
      in_run   = '0;
      in_first = '0;
      for (int i = 0; i < 8; i++) begin
         in_en[i]   = row_en[7-i];
         in_coef[i] = row_coef[(8-i)*COEF_W-1 -: COEF_W];
         in_run[i]  = row_run[(8-i)*RUN_W-1 -: RUN_W];
      end
      for (int i = 7; i >= 0; i--)
         if (in_en[i]) in_first = 3'(i);
   end

   // Lowest-numbered pending lane, and the one after it once cur is consumed
   always_comb begin
      cur = '0;
      nxt = '0;
      for (int i = 7; i >= 0; i--)
         if (mask_q[i]) cur = 3'(i);
      rest = mask_q & ~(8'b1 << cur);
      for (int i = 7; i >= 0; i--)
         if (rest[i]) nxt = 3'(i);
   end

   assign row_ready = init_q && (state == S_IDLE);
   assign accept    = row_valid && row_ready;
   assign is_zrl    = (zrl_q != '0);
   assign sym_valid = (state != S_IDLE);

   always_comb begin
      sym_type = 2'd0;
      sym_run  = 4'd0;
      sym_val  = '0;
      sym_last = 1'b0;
      if (state == S_EMIT) begin
         if (is_zrl) begin
            sym_type = 2'd1;
            sym_run  = 4'hF;
         end else begin
            sym_run  = run_q[cur][3:0];
            sym_val  = coef_q[cur];
            sym_last = last_q && (rest == '0) && (cur == 3'd7);
         end
      end else if (state == S_EOB) begin
         sym_type = 2'd2;
         sym_last = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         init_q <= 1'b0;
         mask_q <= '0;
         last_q <= 1'b0;
         zrl_q  <= '0;
         coef_q <= '0;
         run_q  <= '0;
      end else begin
         init_q <= 1'b1;
         case (state)
            S_IDLE: if (accept) begin
               coef_q <= in_coef;
               run_q  <= in_run;
               mask_q <= in_en;
               last_q <= row_last;
               zrl_q  <= in_run[in_first][RUN_W-1:4];
               if (in_en != '0)   state <= S_EMIT;
               else if (row_last) state <= S_EOB;
            end
            S_EMIT: if (sym_ready) begin
               if (is_zrl) begin
                  zrl_q <= zrl_q - 1'b1;
               end else begin
                  mask_q[cur] <= 1'b0;
                  zrl_q       <= run_q[nxt][RUN_W-1:4];
                  // A row whose final coef is lane8 ends in that coef, otherwise EOB
                  if (rest == '0)
                     state <= (last_q && cur != 3'd7) ? S_EOB : S_IDLE;
               end
            end
            S_EOB: if (sym_ready) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rle_symbol_packer.sv
// Randomised and directed checks of rle_symbol_packer against a symbol-list reference model.
module tb_rle_symbol_packer;

   localparam int COEF_W = 8;
   localparam int RUN_W  = 6;

   typedef struct {
      logic [1:0] t;
      logic [3:0] r;
      logic [7:0] v;
      logic       l;
   } sym_t;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 row_valid = 1'b0;
   logic                 row_ready;
   logic [8*COEF_W-1:0]  row_coef = '0;
   logic [7:0]           row_en = '0;
   logic [8*RUN_W-1:0]   row_run = '0;
   logic                 row_last = 1'b0;
   logic                 sym_valid;
   logic                 sym_ready = 1'b0;
   logic [1:0]           sym_type;
   logic [3:0]           sym_run;
   logic [COEF_W-1:0]    sym_val;
   logic                 sym_last;

   int   passed = 0;
   int   total  = 0;
   sym_t exp_q[$];

   rle_symbol_packer #(.COEF_W(COEF_W), .RUN_W(RUN_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .row_valid(row_valid), .row_ready(row_ready),
      .row_coef(row_coef), .row_en(row_en), .row_run(row_run), .row_last(row_last),
      .sym_valid(sym_valid), .sym_ready(sym_ready),
      .sym_type(sym_type), .sym_run(sym_run), .sym_val(sym_val), .sym_last(sym_last)
   );

   always #5 clk = ~clk;

   function automatic logic [47:0] mk_run(input int lane, input int v);
      logic [47:0] r;
      r = '0;
      r[(9-lane)*6-1 -: 6] = 6'(v);
      return r;
   endfunction

   function automatic logic [63:0] mk_coef(input int lane, input logic [7:0] v);
      logic [63:0] c;
      c = '0;
      c[(9-lane)*8-1 -: 8] = v;
      return c;
   endfunction

   // Symbol list straight from the JPEG AC rules: per nonzero lane, run/16 ZRLs then the coef
   task automatic model(input logic [63:0] c, input logic [7:0] e, input logic [47:0] rn,
                        input logic lst);
      sym_t s;
      int   run;
      exp_q.delete();
      for (int lane = 1; lane <= 8; lane++) begin
         if (e[8-lane]) begin
            run = int'(rn[(9-lane)*6-1 -: 6]);
            for (int k = 0; k < run / 16; k++) begin
               s.t = 2'd1; s.r = 4'hF; s.v = 8'h00; s.l = 1'b0;
               exp_q.push_back(s);
            end
            s.t = 2'd0; s.r = 4'(run % 16); s.v = c[(9-lane)*8-1 -: 8]; s.l = 1'b0;
            exp_q.push_back(s);
         end
      end
      if (lst) begin
         if (e[0]) begin
            s = exp_q[exp_q.size()-1];
            s.l = 1'b1;
            exp_q[exp_q.size()-1] = s;
         end else begin
            s.t = 2'd2; s.r = 4'd0; s.v = 8'h00; s.l = 1'b1;
            exp_q.push_back(s);
         end
      end
   endtask

   task automatic run_row(input string name, input logic [63:0] c, input logic [7:0] e,
                          input logic [47:0] rn, input logic lst, input int prob,
                          input int stall);
      sym_t s, held;
      int   cycles, n;
      logic first, stalled;
      model(c, e, rn, lst);
      n = exp_q.size();
      @(negedge clk);
      row_coef = c; row_en = e; row_run = rn; row_last = lst; row_valid = 1'b1;
      total++;
      if (row_ready !== 1'b1) $display("FAIL %s ready_before: got %b want 1", name, row_ready);
      else passed++;
      @(posedge clk); #1;
      row_valid = 1'b0;
      row_coef = {$urandom, $urandom}; row_en = 8'($urandom); row_run = {16'($urandom), $urandom};
      cycles = 0; first = 1'b1; stalled = 1'b0;
      held = '{default: '0};
      while (exp_q.size() != 0 && cycles < 200) begin
         sym_ready = (cycles < stall) ? 1'b0 : (($urandom % 100) < prob);
         @(negedge clk);
         if (first) begin
            total++;
            if (sym_valid !== 1'b1) $display("FAIL %s first_valid: got %b want 1", name, sym_valid);
            else passed++;
            first = 1'b0;
         end
         if (stalled) begin
            total++;
            if (sym_valid !== 1'b1 || sym_type !== held.t || sym_run !== held.r ||
                sym_val !== held.v || sym_last !== held.l)
               $display("FAIL %s stall_hold: got v%b t%0d r%h val%h l%b want v1 t%0d r%h val%h l%b",
                        name, sym_valid, sym_type, sym_run, sym_val, sym_last,
                        held.t, held.r, held.v, held.l);
            else passed++;
         end
         if (sym_valid === 1'b1 && sym_ready) begin
            s = exp_q.pop_front();
            total++;
            if (sym_type !== s.t || sym_run !== s.r || sym_val !== s.v || sym_last !== s.l ||
                row_ready !== 1'b0)
               $display("FAIL %s sym: got t%0d r%h val%h l%b rdy%b want t%0d r%h val%h l%b rdy0",
                        name, sym_type, sym_run, sym_val, sym_last, row_ready, s.t, s.r, s.v, s.l);
            else passed++;
         end
         stalled = (sym_valid === 1'b1) && !sym_ready;
         held.t = sym_type; held.r = sym_run; held.v = sym_val; held.l = sym_last;
         @(posedge clk); #1;
         cycles++;
      end
      sym_ready = 1'b0;
      if (exp_q.size() != 0) begin
         total++;
         $display("FAIL %s timeout: %0d symbols missing", name, exp_q.size());
         exp_q.delete();
      end
      if (prob == 100 && stall == 0) begin
         total++;
         if (cycles != n) $display("FAIL %s throughput: got %0d cycles want %0d", name, cycles, n);
         else passed++;
      end
      @(negedge clk);
      total++;
      if (row_ready !== 1'b1 || sym_valid !== 1'b0)
         $display("FAIL %s drained: got rdy%b vld%b want rdy1 vld0", name, row_ready, sym_valid);
      else passed++;
   endtask

   task automatic test_reset();
      #2;
      total++;
      if (sym_valid !== 1'b0 || sym_type !== 2'd0 || sym_run !== 4'd0 || sym_val !== 8'd0 ||
          sym_last !== 1'b0)
         $display("FAIL reset_outputs: got v%b t%0d r%h val%h l%b want all 0",
                  sym_valid, sym_type, sym_run, sym_val, sym_last);
      else passed++;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      total++;
      if (row_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", row_ready);
      else passed++;
   endtask

   task automatic test_directed();
      run_row("t1_two_lanes", mk_coef(1, 8'h12) | mk_coef(8, 8'h05), 8'b1000_0001,
              mk_run(1, 0) | mk_run(8, 6), 1'b0, 100, 0);
      run_row("t2_run37", mk_coef(3, 8'h7F), 8'b0010_0000, mk_run(3, 37) | mk_run(5, 50),
              1'b0, 100, 0);
      run_row("t3_last_eob", mk_coef(2, 8'hFE), 8'b0100_0000, mk_run(2, 9), 1'b1, 100, 0);
      run_row("t4_last_lane8", mk_coef(8, 8'h9C), 8'b0000_0001, mk_run(8, 0), 1'b1, 100, 0);
      run_row("t5_empty_last", 64'h0, 8'h00, 48'h0, 1'b1, 100, 0);
      run_row("t5_empty", 64'h0, 8'h00, 48'hFFFF_FFFF_FFFF, 1'b0, 100, 0);
      run_row("run63", mk_coef(4, 8'h80), 8'b0001_0001, mk_run(4, 63) | mk_run(8, 16),
              1'b1, 100, 0);
   endtask

   task automatic test_stall();
      run_row("t6_stall", mk_coef(3, 8'h7F), 8'b0010_0000, mk_run(3, 37), 1'b0, 100, 3);
      run_row("stall_rand", {$urandom, $urandom}, 8'hFF, {16'($urandom), $urandom}, 1'b1, 40, 2);
   endtask

   task automatic test_mid_reset();
      @(negedge clk);
      row_coef = mk_coef(1, 8'h11); row_en = 8'b1000_0000; row_run = mk_run(1, 63);
      row_last = 1'b1; row_valid = 1'b1; sym_ready = 1'b1;
      @(posedge clk); #1;
      row_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0; sym_ready = 1'b0;
      #1;
      total++;
      if (sym_valid !== 1'b0 || sym_last !== 1'b0)
         $display("FAIL mid_reset_valid: got v%b l%b want v0 l0", sym_valid, sym_last);
      else passed++;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      total++;
      if (row_ready !== 1'b1 || sym_valid !== 1'b0)
         $display("FAIL mid_reset_ready: got rdy%b vld%b want rdy1 vld0", row_ready, sym_valid);
      else passed++;
      run_row("after_reset", mk_coef(5, 8'h33), 8'b0000_1000, mk_run(5, 20), 1'b1, 100, 0);
   endtask

   task automatic test_random();
      logic [7:0] e;
      for (int i = 0; i < 40; i++) begin
         e = 8'($urandom);
         if (i % 5 == 0) e = e & 8'($urandom);
         run_row("random", {$urandom, $urandom}, e, {16'($urandom), $urandom},
                 1'($urandom), 70, 0);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 6; i++)
         run_row("b2b", {$urandom, $urandom}, 8'($urandom), {16'($urandom), $urandom},
                 1'(i % 2), 100, 0);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_stall();
      test_mid_reset();
      test_random();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
